timer_scheduler: RTL

TIMER_SCHEDULER -- requirements
Module: timer_scheduler

---
 rtl/timer_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/timer_scheduler.sv
// Round-robin scheduler sharing one N-bit countdown counter among R requesters.
// The owner is granted, counts its loaded delay down to zero, then gets a single done pulse.
module timer_scheduler #(
    parameter int N = 3,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] load_val,
    output logic [R-1:0]   gnt,
    output logic [R-1:0]   done,
    output logic [N-1:0]   Q,
    output logic           busy
);

    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [R-1:0]    gnt_q,   gnt_d;
    logic [R-1:0]    done_q,  done_d;
    logic [N-1:0]    cnt_q,   cnt_d;
    logic            busy_q,  busy_d;

    logic [IW-1:0]   winner;
    logic            found;

    // Search upward from last+1 so the most recently serviced index has lowest priority.
    always_comb begin
        int idx;
        winner = last_q;
        found  = 1'b0;
        for (int k = 1; k <= R; k++) begin
            idx = (int'(last_q) + k) % R;
            if (!found && req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        busy_d  = busy_q;

        unique case (state_q)
            IDLE: begin
                gnt_d  = '0;
                cnt_d  = '0;
                busy_d = 1'b0;
                if (found) begin
                    state_d        = COUNT;
                    owner_d        = winner;
                    gnt_d[winner]  = 1'b1;
                    cnt_d          = load_val[int'(winner)*N +: N];
                    busy_d         = 1'b1;
                end
            end

            COUNT: begin
                if (!req[owner_q]) begin
                    // Abandoned by the owner: release silently, still rotate priority.
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    last_d  = owner_q;
                    busy_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d         = DONE;
                    gnt_d           = '0;
                    done_d[owner_q] = 1'b1;
                    busy_d          = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
                last_d  = owner_q;
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(R - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign Q    = cnt_q;
    assign busy = busy_q;

endmodule
